// File: rtl/shift_right_seq_pkg.sv
// Shared definitions for the sequential right shifter: FSM encoding and
// default geometry.
package shift_right_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_N  = 32;
  localparam int DEF_SW = 5;

endpackage

// File: rtl/shift_right_seq_srl_stage.sv
// One barrel-shifter stage: shifts right by 2^K when enabled, filling the
// vacated upper bits with the supplied fill bit.
module srl_stage
  import shift_right_seq_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int K = 0
) (
  input  logic [N-1:0] din,
  input  logic         en,
  input  logic         fill,
  output logic [N-1:0] dout
);

  localparam int S = 2 ** K;

  always_comb begin
    dout = din;
    if (en) begin
      dout = {{S{fill}}, din[N-1:S]};
    end
  end

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter: applies one power-of-two stage per cycle, so
// every shift takes exactly SW cycles regardless of the amount.
module shift_right_seq
  import shift_right_seq_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int SW = DEF_SW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  X,
  input  logic [31:0]   Y,
  input  logic          arith,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  Z
);

  localparam logic [SW-1:0] LAST_CNT = SW'(SW - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  work_q, work_d;
  logic [SW-1:0] amt_q, amt_d;
  logic          mode_q, mode_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  z_q, z_d;

  logic [N-1:0]  stage_out [SW];
  logic [N-1:0]  stage_res;
  logic          fill;
  logic          unused_y;

  assign unused_y = ^Y[31:SW];

  // Arithmetic fill preserves the MSB each stage, so the working register's
  // top bit always equals the captured sign.
  assign fill = mode_q & work_q[N-1];

  for (genvar k = 0; k < SW; k++) begin : g_stage
    srl_stage #(.N(N), .K(k)) u_stage (
      .din  (work_q),
      .en   (amt_q[k]),
      .fill (fill),
      .dout (stage_out[k])
    );
  end

  always_comb begin
    stage_res = work_q;
    for (int i = 0; i < SW; i++) begin
      if (cnt_q == SW'(i)) begin
        stage_res = stage_out[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    amt_d   = amt_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = X;
          amt_d   = Y[SW-1:0];
          mode_d  = arith;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = stage_res;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          z_d     = stage_res;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      amt_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Z         = z_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Scoreboard bench for shift_right_seq: directed operands push expected
// results; a monitor checks value, latency and stability whenever Z is valid.
module tb_shift_right_seq;

  localparam int N  = 32;
  localparam int SW = 5;

  typedef struct {
    logic [N-1:0] z;
    int           acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  X = '0;
  logic [31:0]   Y = '0;
  logic          arith = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  Z;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   lastAcc = 0;
  logic prevValid = 1'b0;

  shift_right_seq #(.N(N), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Waits for in_ready, presents one operand and queues its hand-computed result.
  task automatic applyStimulus(input logic [N-1:0] x, input logic [31:0] y,
                               input logic a, input logic [N-1:0] expZ);
    int tries = 0;
    exp_t e;
    while (!in_ready) begin
      @(negedge clk);
      tries++;
      if (tries > 100) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1");
        return;
      end
    end
    X = x;
    Y = y;
    arith = a;
    in_valid = 1'b1;
    e.z = expZ;
    e.acc = cycle + 1;
    lastAcc = e.acc;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int tries = 0;
    while (expQ.size() != 0) begin
      @(negedge clk);
      tries++;
      if (tries > 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL drain_timeout: %0d results pending, required 0", expQ.size());
        expQ.delete();
        return;
      end
    end
    @(negedge clk);
  endtask

  // Monitor: every valid cycle compares Z to the head of the queue; the first
  // valid cycle also checks latency, and the handshake cycle pops the entry.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: Z=0x%08h with no result pending", Z);
      end else begin
        if (!prevValid) checkOutput("latency", cycle - expQ[0].acc, SW);
        checkOutput("z_result", Z, expQ[0].z);
        checkOutput("in_ready_busy", {31'd0, in_ready}, 32'd0);
        if (out_ready) void'(expQ.pop_front());
      end
    end
    prevValid = out_valid;
  end

  initial begin
    int acc1;
    #2;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_z", Z, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First accept on the very first edge after reset release.
    applyStimulus(32'h8000_0000, 32'd4, 1'b0, 32'h0800_0000);
    applyStimulus(32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000);
    applyStimulus(32'hFFFF_0000, 32'h25, 1'b0, 32'h07FF_F800);
    applyStimulus(32'h8000_0000, 32'd31, 1'b0, 32'h0000_0001);
    applyStimulus(32'h8000_0000, 32'd31, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(32'h1234_5678, 32'd0, 1'b1, 32'h1234_5678);
    applyStimulus(32'h7FFF_FFFF, 32'd1, 1'b1, 32'h3FFF_FFFF);
    applyStimulus(32'hF0F0_F0F0, 32'd8, 1'b1, 32'hFFF0_F0F0);
    applyStimulus(32'hF0F0_F0F0, 32'd8, 1'b0, 32'h00F0_F0F0);
    applyStimulus(32'hA5A5_A5A5, 32'hFFFF_FF13, 1'b0, 32'h0000_14B4);
    acc1 = lastAcc;
    applyStimulus(32'hA5A5_A5A5, 32'd19, 1'b1, 32'hFFFF_F4B4);
    checkOutput("throughput", lastAcc - acc1, SW + 2);
    waitDrain();
    checkOutput("z_hold_after_handshake", Z, 32'hFFFF_F4B4);

    // Backpressure: hold the result while a new operand waits at the input.
    out_ready = 1'b0;
    applyStimulus(32'h0000_FF00, 32'd4, 1'b0, 32'h0000_0FF0);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
    X = 32'hDEAD_BEEF;
    Y = 32'd16;
    arith = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    applyStimulus(32'hDEAD_BEEF, 32'd16, 1'b1, 32'hFFFF_DEAD);
    waitDrain();

    // Abort in the middle of a shift; the result must be discarded.
    applyStimulus(32'h8000_0000, 32'd3, 1'b1, 32'hF000_0000);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("abort_z", Z, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'h0F00_0000, 32'd12, 1'b0, 32'h0000_F000);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
